// File: rtl/gpio_serial_loader_pkg.sv
// Shared constants, FSM state type and config-word field layout for the
// serial pad-configuration loader.
package gpio_cfg_pkg;

    localparam int CFG_BITS         = 13;
    localparam logic [CFG_BITS-1:0] CFG_RESET = 13'h0403;
    localparam int NUM_PADS_DEFAULT = 38;
    localparam int CLK_DIV_DEFAULT  = 2;

    // Bit positions of the fields inside one pad configuration word
    localparam int CFG_MGMT_ENA   = 0;
    localparam int CFG_OEB        = 1;
    localparam int CFG_HOLD       = 2;
    localparam int CFG_INP_DIS    = 3;
    localparam int CFG_IB_MODE    = 4;
    localparam int CFG_ANALOG_EN  = 5;
    localparam int CFG_ANALOG_SEL = 6;
    localparam int CFG_ANALOG_POL = 7;
    localparam int CFG_SLOW       = 8;
    localparam int CFG_VTRIP      = 9;
    localparam int CFG_DM_LSB     = 10;
    localparam int CFG_DM_MSB     = 12;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_HI,
        LOAD_LO
    } state_e;

    // Index width for a range of n entries, never narrower than one bit
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Register-port address width; it can also hold NUM_PADS itself so an
    // out-of-range pad index is always expressible on the port
    function automatic int addr_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Firmware register port and pad-chain outputs of the serial loader.
interface gpio_serial_loader_if #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13
);
    localparam int ADDR_W = gpio_cfg_pkg::addr_bits(NUM_PADS);

    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [CFG_BITS-1:0] cfg_wdata;
    logic [CFG_BITS-1:0] cfg_rdata;
    logic                start;
    logic                busy;
    logic                done;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;
    logic                serial_resetn;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start,
        input  cfg_rdata, busy, done,
        input  serial_clock, serial_data, serial_load, serial_resetn
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start,
        output cfg_rdata, busy, done,
        output serial_clock, serial_data, serial_load, serial_resetn
    );

endinterface

// File: rtl/gpio_serial_loader_tick.sv
// Half-period timebase for the pad chain: one-cycle tick every CLK_DIV
// cycles while enabled, restarted from zero when a transfer begins.
module serial_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_W'(CLK_DIV - 1));

    // Count cycles within the current half-period, wrapping on each tick
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Holds the per-pad configuration words and shifts them, highest pad first
// and MSB first, into the pad control-block chain, then strobes load.
module gpio_serial_loader #(
    parameter int NUM_PADS = gpio_cfg_pkg::NUM_PADS_DEFAULT,
    parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS,
    parameter logic [CFG_BITS-1:0] CFG_RESET = CFG_BITS'(gpio_cfg_pkg::CFG_RESET),
    parameter int CLK_DIV  = gpio_cfg_pkg::CLK_DIV_DEFAULT
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    gpio_serial_loader_if.slave  bus
);
    import gpio_cfg_pkg::*;

    localparam int PAD_W  = idx_bits(NUM_PADS);
    localparam int BIT_W  = idx_bits(CFG_BITS);
    localparam int ADDR_W = addr_bits(NUM_PADS);

    state_e              state_q, state_d;
    logic [PAD_W-1:0]    pad_q, pad_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CFG_BITS-1:0] cfg_q [NUM_PADS];
    logic [CFG_BITS-1:0] cfg_d [NUM_PADS];
    logic [CFG_BITS-1:0] rdata;
    logic                serial_clock_q, serial_clock_d;
    logic                serial_data_q, serial_data_d;
    logic                serial_load_q, serial_load_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                resetn_q;
    logic                write_ok;
    logic                running;
    logic                restart;
    logic                tick;

    assign running  = (state_q != IDLE);
    assign write_ok = bus.cfg_we && (state_q == IDLE);

    serial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .enable  (running),
        .restart (restart),
        .tick    (tick)
    );

    // Next array contents: an idle write to an in-range pad replaces its word
    always_comb begin
        cfg_d = cfg_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (write_ok && (bus.cfg_addr == ADDR_W'(i))) begin
                cfg_d[i] = bus.cfg_wdata;
            end
        end
    end

    // Combinational readback; out-of-range addresses read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (bus.cfg_addr == ADDR_W'(i)) begin
                rdata = cfg_q[i];
            end
        end
    end

    // Configuration array storage
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                cfg_q[i] <= CFG_RESET;
            end
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Transfer sequencing: walk pad/bit indices one bit per clock period
    always_comb begin
        state_d = state_q;
        pad_d   = pad_q;
        bit_d   = bit_q;
        restart = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT_LO;
                    pad_d   = PAD_W'(NUM_PADS - 1);
                    bit_d   = BIT_W'(CFG_BITS - 1);
                    restart = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if ((pad_q == '0) && (bit_q == '0)) begin
                        state_d = LOAD_HI;
                    end else begin
                        state_d = SHIFT_LO;
                        if (bit_q == '0) begin
                            bit_d = BIT_W'(CFG_BITS - 1);
                            pad_d = pad_q - 1'b1;
                        end else begin
                            bit_d = bit_q - 1'b1;
                        end
                    end
                end
            end
            LOAD_HI: begin
                if (tick) begin
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs follow the next state so they are registered alongside it;
    // data reads the post-write array so a same-cycle write is shifted out
    always_comb begin
        serial_clock_d = (state_d == SHIFT_HI);
        serial_load_d  = (state_d == LOAD_HI);
        busy_d         = (state_d != IDLE);
        serial_data_d  = 1'b0;
        if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) begin
            serial_data_d = cfg_d[pad_d][bit_d];
        end
    end

    // State, index and output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q        <= IDLE;
            pad_q          <= '0;
            bit_q          <= '0;
            serial_clock_q <= 1'b0;
            serial_data_q  <= 1'b0;
            serial_load_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pad_q          <= pad_d;
            bit_q          <= bit_d;
            serial_clock_q <= serial_clock_d;
            serial_data_q  <= serial_data_d;
            serial_load_q  <= serial_load_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Chain reset held low through block reset, released one clock later
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            resetn_q <= 1'b0;
        end else begin
            resetn_q <= 1'b1;
        end
    end

    assign bus.cfg_rdata     = rdata;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.serial_clock  = serial_clock_q;
    assign bus.serial_data   = serial_data_q;
    assign bus.serial_load   = serial_load_q;
    assign bus.serial_resetn = resetn_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: default geometry plus a tiny
// CLK_DIV=1, 2-pad, 3-bit instance.
module tb_gpio_serial_loader;

    localparam int NP  = 38;
    localparam int CB  = 13;
    localparam int CD  = 2;
    localparam int SNP = 2;
    localparam int SCB = 3;
    localparam int SCD = 1;

    logic wb_clk_i = 1'b0;
    logic rst;
    logic rst_s;

    always #5 wb_clk_i = ~wb_clk_i;

    gpio_serial_loader_if #(.NUM_PADS(NP), .CFG_BITS(CB)) bus ();
    gpio_serial_loader_if #(.NUM_PADS(SNP), .CFG_BITS(SCB)) sbus ();

    gpio_serial_loader #(
        .NUM_PADS (NP), .CFG_BITS (CB), .CFG_RESET (13'h0403), .CLK_DIV (CD)
    ) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (rst), .bus (bus)
    );

    gpio_serial_loader #(
        .NUM_PADS (SNP), .CFG_BITS (SCB), .CFG_RESET (3'b101), .CLK_DIV (SCD)
    ) dut_s (
        .wb_clk_i (wb_clk_i), .wb_rst_i (rst_s), .bus (sbus)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [5:0]  addr;
        logic [12:0] wdata;
        logic [12:0] exp_rdata;
    } vec_t;

    vec_t        vecs [7];
    logic [12:0] model [NP];
    logic        stream [$];
    int          checks = 0;
    int          errors = 0;
    int          n_rise, n_busy, n_done, n_load, load_w, n_unstable;
    logic        timed_out, done_at_fall;

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.cfg_we    = v.we;
        bus.cfg_addr  = v.addr;
        bus.cfg_wdata = v.wdata;
        step();
        bus.cfg_we = 1'b0;
        if (v.we && (v.addr < NP)) model[v.addr] = v.wdata;
        checkOutput(v.name, bus.cfg_rdata, v.exp_rdata);
    endtask

    function automatic logic [12:0] get_word(input int w);
        logic [12:0] r = '0;
        for (int j = 0; j < CB; j++) begin
            if (w * CB + j < stream.size()) r = {r[11:0], stream[w * CB + j]};
        end
        return r;
    endfunction

    // Pulse start (optionally with a write), then monitor until busy falls
    task automatic run_transfer(input int inject_at, input logic [5:0] inj_addr,
                                input logic [12:0] inj_wdata, input logic sw_we,
                                input logic [5:0] sw_addr, input logic [12:0] sw_wdata);
        logic prev_clk, prev_data, prev_load, finished;
        n_rise = 0; n_busy = 0; n_done = 0; n_load = 0; load_w = 0; n_unstable = 0;
        done_at_fall = 1'b0;
        stream.delete();
        bus.start     = 1'b1;
        bus.cfg_we    = sw_we;
        bus.cfg_addr  = sw_addr;
        bus.cfg_wdata = sw_wdata;
        step();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        prev_clk = 1'b0; prev_data = 1'b0; prev_load = 1'b0; finished = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (bus.serial_clock && !prev_clk) begin
                n_rise++;
                stream.push_back(bus.serial_data);
                if (bus.serial_data !== prev_data) n_unstable++;
            end
            if (bus.serial_load && !prev_load) n_load++;
            if (bus.serial_load) load_w++;
            if (bus.done) n_done++;
            if (!bus.busy) begin
                done_at_fall = bus.done;
                finished = 1'b1;
                break;
            end
            n_busy++;
            prev_clk = bus.serial_clock; prev_data = bus.serial_data; prev_load = bus.serial_load;
            if (c == inject_at) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = inj_addr; bus.cfg_wdata = inj_wdata; bus.start = 1'b1;
            end else begin
                bus.cfg_we = 1'b0; bus.start = 1'b0;
            end
            step();
        end
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        timed_out = !finished;
    endtask

    task automatic check_transfer(input string tag);
        checkOutput({tag, "_timeout"}, timed_out, 0);
        checkOutput({tag, "_busy_cycles"}, n_busy, 1980);
        checkOutput({tag, "_clock_rises"}, n_rise, NP * CB);
        checkOutput({tag, "_done_pulses"}, n_done, 1);
        checkOutput({tag, "_done_at_busy_fall"}, done_at_fall, 1);
        checkOutput({tag, "_load_pulses"}, n_load, 1);
        checkOutput({tag, "_load_width"}, load_w, 2);
        checkOutput({tag, "_data_unstable"}, n_unstable, 0);
    endtask

    task automatic check_stream(input string tag);
        int bad = 0;
        for (int k = 0; k < NP * CB; k++) begin
            if (k >= stream.size()) bad++;
            else if (stream[k] !== model[NP - 1 - k / CB][CB - 1 - k % CB]) bad++;
        end
        checkOutput({tag, "_stream_bad_bits"}, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_seen;
        logic [5:0] sstream;
        int s_busy, s_done, s_rise;
        logic s_prev_clk, s_finished;

        vecs[0] = '{"wr_pad0_1fff",   1'b1, 6'd0,  13'h1FFF, 13'h1FFF};
        vecs[1] = '{"wr_pad37_0001",  1'b1, 6'd37, 13'h0001, 13'h0001};
        vecs[2] = '{"wr_addr40_oob",  1'b1, 6'd40, 13'h1234, 13'h0000};
        vecs[3] = '{"rd_pad5_default", 1'b0, 6'd5, 13'h0000, 13'h0403};
        vecs[4] = '{"wr_addr63_oob",  1'b1, 6'd63, 13'h0AAA, 13'h0000};
        vecs[5] = '{"wr_pad20_0c0f",  1'b1, 6'd20, 13'h0C0F, 13'h0C0F};
        vecs[6] = '{"rd_pad0_back",   1'b0, 6'd0,  13'h0000, 13'h1FFF};
        for (int i = 0; i < NP; i++) model[i] = 13'h0403;

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.start = 1'b0;
        sbus.cfg_we = 1'b0; sbus.cfg_addr = '0; sbus.cfg_wdata = '0; sbus.start = 1'b0;
        rst = 1'b1; rst_s = 1'b1;
        repeat (3) step();

        // Reset state
        checkOutput("reset_outputs", {bus.busy, bus.done, bus.serial_clock, bus.serial_data, bus.serial_load}, 0);
        checkOutput("reset_resetn_low", bus.serial_resetn, 0);
        checkOutput("reset_rdata_pad0", bus.cfg_rdata, 13'h0403);
        rst = 1'b0; rst_s = 1'b0;
        checkOutput("resetn_before_clock", bus.serial_resetn, 0);
        step();
        checkOutput("resetn_after_release", bus.serial_resetn, 1);

        // Transfer of the reset contents straight after reset
        run_transfer(-1, 6'd0, 13'h0, 1'b0, 6'd0, 13'h0);
        check_transfer("t1");
        check_stream("t1");
        step();
        checkOutput("t1_done_one_cycle", bus.done, 0);

        // Table-driven register port accesses while idle
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Transfer with edited pads: pad 37 leads, pad 0 trails
        run_transfer(-1, 6'd0, 13'h0, 1'b0, 6'd0, 13'h0);
        check_transfer("t2");
        check_stream("t2");
        checkOutput("t2_first_word", get_word(0), 13'h0001);
        checkOutput("t2_pad20_word", get_word(17), 13'h0C0F);
        checkOutput("t2_last_word", get_word(NP - 1), 13'h1FFF);
        step();

        // Write and start while busy are both ignored
        run_transfer(100, 6'd5, 13'h1AAA, 1'b0, 6'd0, 13'h0);
        check_transfer("t3");
        check_stream("t3");
        bus.cfg_addr = 6'd5;
        #1;
        checkOutput("t3_pad5_unchanged", bus.cfg_rdata, 13'h0403);

        // Back-to-back start carrying a same-cycle write to pad 37
        model[37] = 13'h1555;
        run_transfer(-1, 6'd0, 13'h0, 1'b1, 6'd37, 13'h1555);
        check_transfer("t4");
        check_stream("t4");
        checkOutput("t4_first_word", get_word(0), 13'h1555);
        step();
        checkOutput("t4_done_dropped", bus.done, 0);
        bus.cfg_addr = 6'd37;
        #1;
        checkOutput("t4_pad37_readback", bus.cfg_rdata, 13'h1555);

        // Reset in the middle of a transfer at the 200th clock rise
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_rise = 0;
        s_prev_clk = 1'b0;
        s_finished = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus.serial_clock && !s_prev_clk) n_rise++;
            if (n_rise == 200) begin
                s_finished = 1'b1;
                break;
            end
            s_prev_clk = bus.serial_clock;
            step();
        end
        checkOutput("t5_reached_bit200", s_finished, 1);
        rst = 1'b1;
        #1;
        checkOutput("t5_outputs_cleared", {bus.busy, bus.done, bus.serial_clock, bus.serial_data, bus.serial_load}, 0);
        checkOutput("t5_resetn_low", bus.serial_resetn, 0);
        checkOutput("t5_pad37_reloaded", bus.cfg_rdata, 13'h0403);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.done) done_seen++;
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.done) done_seen++;
        end
        checkOutput("t5_no_done", done_seen, 0);
        checkOutput("t5_idle_after", bus.busy, 0);
        checkOutput("t5_resetn_high", bus.serial_resetn, 1);
        bus.cfg_addr = 6'd0;
        #1;
        checkOutput("t5_pad0_reloaded", bus.cfg_rdata, 13'h0403);

        // Small geometry: out-of-range write, readback and transfer length
        sbus.cfg_we = 1'b1; sbus.cfg_addr = 2'd3; sbus.cfg_wdata = 3'b010;
        step();
        sbus.cfg_we = 1'b0;
        checkOutput("s_oob_read", sbus.cfg_rdata, 0);
        sbus.cfg_addr = 2'd2;
        #1;
        checkOutput("s_addr2_read", sbus.cfg_rdata, 0);
        sbus.cfg_we = 1'b1; sbus.cfg_addr = 2'd1; sbus.cfg_wdata = 3'b110;
        step();
        sbus.cfg_we = 1'b0;
        checkOutput("s_pad1_read", sbus.cfg_rdata, 3'b110);
        sbus.cfg_addr = 2'd0;
        #1;
        checkOutput("s_pad0_default", sbus.cfg_rdata, 3'b101);
        sbus.start = 1'b1;
        step();
        sbus.start = 1'b0;
        s_busy = 0; s_done = 0; s_rise = 0; sstream = '0;
        s_prev_clk = 1'b0; s_finished = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (sbus.serial_clock && !s_prev_clk) begin
                s_rise++;
                sstream = {sstream[4:0], sbus.serial_data};
            end
            if (sbus.done) s_done++;
            if (!sbus.busy) begin
                s_finished = 1'b1;
                break;
            end
            s_busy++;
            s_prev_clk = sbus.serial_clock;
            step();
        end
        checkOutput("s_timeout", s_finished, 1);
        checkOutput("s_busy_cycles", s_busy, 14);
        checkOutput("s_clock_rises", s_rise, 6);
        checkOutput("s_done_pulses", s_done, 1);
        checkOutput("s_stream", sstream, 6'b110101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
